// File: rtl/ram_sdp_init.sv
// ============================================================================
// Module   : ram_sdp_init
// Brief    : Simple-dual-port RAM with registered read, write-first bypass and
//            a hardware init sequencer. Optional boot image: RAM_BOOT_IMAGE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_sdp_init #(
  parameter int          DATA_W = 8,
  parameter int          ADDR_W = 8,
  parameter int unsigned FILL   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid
);

  localparam int                c_depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_last  = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] c_fill  = DATA_W'(FILL);

`ifdef RAM_BOOT_IMAGE_EN
  // Tiny boot loop for the core: inc r0 / jnc 0 / mvi 0 / jmp 0.
  localparam logic [DATA_W-1:0] c_boot0 = DATA_W'(8'h60);
  localparam logic [DATA_W-1:0] c_boot1 = DATA_W'(8'h80);
  localparam logic [DATA_W-1:0] c_boot2 = DATA_W'(8'hA0);
  localparam logic [DATA_W-1:0] c_boot3 = DATA_W'(8'h90);
`endif

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic [ADDR_W-1:0]   w_init_cnt_nxt;

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_rd_en;
  logic                w_collide;

  logic [DATA_W-1:0]   r_mem [c_depth];

  function automatic logic [DATA_W-1:0] f_image(input logic [ADDR_W-1:0] a);
    f_image = c_fill;
`ifdef RAM_BOOT_IMAGE_EN
    case (int'(a))
      0:       f_image = c_boot0;
      1:       f_image = c_boot1;
      2:       f_image = c_boot2;
      3:       f_image = c_boot3;
      default: f_image = c_fill;
    endcase
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // The single array write port is shared between the fill and user writes.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_mem_we       = 1'b0;
    w_mem_addr     = w_addr;
    w_mem_wdata    = w_data;
    w_rd_en        = 1'b0;
    case (r_state)
      S_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_init_cnt;
        w_mem_wdata = f_image(r_init_cnt);
        if (r_init_cnt == c_last) begin
          w_state_nxt    = S_READY;
          w_init_cnt_nxt = '0;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 1'b1;
        end
      end
      S_READY: begin
        if (init_req) begin
          w_state_nxt    = S_INIT;
          w_init_cnt_nxt = '0;
        end else begin
          w_mem_we = we;
          w_rd_en  = re;
        end
      end
      default: begin
        w_state_nxt    = S_INIT;
        w_init_cnt_nxt = '0;
      end
    endcase
  end

  assign w_collide = we && (w_addr == r_addr);
  assign ready     = (r_state == S_READY);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_rd_en;
      if (w_rd_en) begin
        r_data <= w_collide ? w_data : r_mem[r_addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_sdp_init.sv
// ============================================================================
// Module   : tb_ram_sdp_init
// Brief    : Directed + randomized bench for ram_sdp_init against an array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_sdp_init;

  localparam int         DATA_W = 8;
  localparam int         ADDR_W = 8;
  localparam int         DEPTH  = 256;
  localparam logic [7:0] FILL   = 8'h00;

  logic              clk;
  logic              rst_n;
  logic              init_req;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              re;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  ram_sdp_init #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .FILL  (int'(FILL))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .init_req(init_req),
    .ready   (ready),
    .we      (we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .re      (re),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .r_valid (r_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: array contents, remaining fill edges, expected read port.
  logic [7:0] ref_mem [DEPTH];
  int         init_left;
  logic       exp_valid;
  logic [7:0] exp_rdata;

  function automatic logic [7:0] image(input int a);
`ifdef RAM_BOOT_IMAGE_EN
    if (a == 0) return 8'h60;
    if (a == 1) return 8'h80;
    if (a == 2) return 8'hA0;
    if (a == 3) return 8'h90;
`endif
    return FILL;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ready"},   {31'd0, ready},   {31'd0, (init_left == 0)});
    check({tag, ".r_valid"}, {31'd0, r_valid}, {31'd0, exp_valid});
    check({tag, ".r_data"},  {24'd0, r_data},  {24'd0, exp_rdata});
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then check.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      init_left = DEPTH;
      exp_valid = 1'b0;
      exp_rdata = 8'h00;
    end else if (init_left > 0) begin
      ref_mem[DEPTH - init_left] = image(DEPTH - init_left);
      init_left--;
      exp_valid = 1'b0;
    end else if (init_req) begin
      init_left = DEPTH;
      exp_valid = 1'b0;
    end else begin
      if (re) exp_rdata = (we && w_addr == r_addr) ? w_data : ref_mem[r_addr];
      exp_valid = re;
      if (we) ref_mem[w_addr] = w_data;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic iwe, input logic [7:0] wa, input logic [7:0] wd,
                       input logic ire, input logic [7:0] ra, input logic ireq,
                       input string tag);
    we = iwe; w_addr = wa; w_data = wd; re = ire; r_addr = ra; init_req = ireq;
    cycle(tag);
  endtask

  task automatic rand_cycle(input string tag, input int amask);
    drive(1'($urandom), 8'($urandom) & 8'(amask), 8'($urandom),
          1'($urandom), 8'($urandom) & 8'(amask), 1'b0, tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    init_left = DEPTH;
    exp_valid = 1'b0;
    exp_rdata = 8'h00;
    check_outputs(tag);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, tag);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; init_req = 1'b0; we = 1'b0; re = 1'b0;
    w_addr = '0; w_data = '0; r_addr = '0;
    init_left = DEPTH; exp_valid = 1'b0; exp_rdata = 8'h00;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hxx;

    // Reset values, then release and fill with port traffic that must be ignored.
    #2;
    check_outputs("reset");
    cycle("reset_hold");
    cycle("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 49) drive(1'b1, 8'h05, 8'hFF, 1'b1, 8'h05, 1'b0, "init_traffic");
      else         rand_cycle("init_rand", 8'hFF);
    end
    check("ready_after_fill", {31'd0, ready}, 32'd1);

    // Full sweep of back-to-back reads.
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 8'h00, 8'h00, 1'b1, 8'(a), 1'b0, "sweep");
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "sweep_end");
    check("sweep_valid_drop", {31'd0, r_valid}, 32'd0);

    // Directed write/read, neighbour, collision, ignored init-time write.
    drive(1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0, "wr_10");
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b0, "rd_10");
    check("rd_10_const", {24'd0, r_data}, 32'h5A);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0, "rd_11");
    drive(1'b1, 8'h20, 8'hC3, 1'b1, 8'h20, 1'b0, "collide_20");
    check("collide_const", {24'd0, r_data}, 32'hC3);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b0, "rd_20");
    check("rd_20_const", {24'd0, r_data}, 32'hC3);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 1'b0, "rd_05");
    check("rd_05_fill", {24'd0, r_data}, {24'd0, FILL});
    drive(1'b1, 8'h40, 8'h11, 1'b1, 8'h41, 1'b0, "diff_addr");

`ifdef RAM_BOOT_IMAGE_EN
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "boot0"); check("boot0_const", {24'd0, r_data}, 32'h60);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "boot1"); check("boot1_const", {24'd0, r_data}, 32'h80);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 1'b0, "boot2"); check("boot2_const", {24'd0, r_data}, 32'hA0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 1'b0, "boot3"); check("boot3_const", {24'd0, r_data}, 32'h90);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h04, 1'b0, "boot4"); check("boot4_const", {24'd0, r_data}, 32'h00);
`endif

    // Random traffic on a small window to provoke collisions.
    for (int i = 0; i < 400; i++) rand_cycle("traffic", 8'h0F);

    // init_req with simultaneous traffic; a second pulse mid-fill is ignored.
    drive(1'b1, 8'h30, 8'hAA, 1'b0, 8'h00, 1'b0, "wr_30");
    drive(1'b1, 8'h31, 8'h77, 1'b1, 8'h30, 1'b1, "init_req");
    check("init_req_ready_low", {31'd0, ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "req_in_init");
      else         rand_cycle("refill", 8'hFF);
    end
    check("refill_ready", {31'd0, ready}, 32'd1);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 1'b0, "rd_30");
    check("rd_30_fill", {24'd0, r_data}, {24'd0, FILL});
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h31, 1'b0, "rd_31");

    // Reset asserted 100 edges into a fill, then a clean full fill.
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "init_req2");
    for (int i = 0; i < 100; i++) rand_cycle("partial", 8'hFF);
    async_reset("mid_init_rst");
    for (int i = 0; i < DEPTH; i++) rand_cycle("fill3", 8'hFF);
    for (int i = 0; i < 60; i++) rand_cycle("traffic2", 8'h07);

    // Reset during active reads drops r_valid and clears r_data immediately.
    drive(1'b1, 8'h08, 8'hE7, 1'b0, 8'h00, 1'b0, "wr_08");
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h08, 1'b0, "rd_08");
    check("rd_08_const", {24'd0, r_data}, 32'hE7);
    async_reset("mid_traffic_rst");
    for (int i = 0; i < DEPTH; i++) rand_cycle("fill4", 8'hFF);
    for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 1'b0, "final_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
